// File: rtl/truth_table_sweeper.sv
// Steps an N-input vector through every combination, holds each row for SETTLE_CYCLES and packs Y into a truth table.
// Optional MINTERM_COUNT_EN adds ones_count, the number of rows where Y was 1.
module truth_table_sweeper #(
  parameter int unsigned N_INPUTS      = 4,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     y_in,
  output logic [N_INPUTS-1:0]      vec_out,
  output logic                     busy,
  output logic                     done,
  output logic [2**N_INPUTS-1:0]   table_out
`ifdef MINTERM_COUNT_EN
  ,
  output logic [N_INPUTS:0]        ones_count
`endif
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [N_INPUTS-1:0] LAST_ROW = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } stateT;

  stateT            state;
  logic [CNT_W-1:0] settleCnt;

  // Single registered FSM: every output is a flop, so y_in never reaches a port combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      settleCnt <= '0;
      vec_out   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      table_out <= '0;
`ifdef MINTERM_COUNT_EN
      ones_count <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= SETTLE;
            vec_out   <= '0;
            settleCnt <= CNT_RELOAD;
            table_out <= '0;
            busy      <= 1'b1;
`ifdef MINTERM_COUNT_EN
            ones_count <= '0;
`endif
          end
        end
        SETTLE: begin
          if (settleCnt != '0) begin
            settleCnt <= settleCnt - CNT_W'(1);
          end else begin
            table_out[vec_out] <= y_in;
`ifdef MINTERM_COUNT_EN
            ones_count <= ones_count + (N_INPUTS + 1)'(y_in);
`endif
            // Last row stops here so vec_out never wraps past all-ones.
            if (vec_out == LAST_ROW) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              vec_out   <= vec_out + N_INPUTS'(1);
              settleCnt <= CNT_RELOAD;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
